core_sequencer: RTL and testbench

Upstream control stage for the array of `core` instances. It accepts one command at a time from the host-side command port (valid/ready). It expands each command into the multi-cycle pattern of broadcast-bus and control strobes that every core consumes: core selection, input mux select, ALU opcode, output mux select and output enable. It also captures read-back data from the shared 16-bit RAM bus and returns it on a response port with its own valid/ready handshake.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/core_sequencer_if.sv | 25 ++
 rtl/core_sequencer.sv | 146 ++++++++++++++
 tb/tb_core_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core array control path: command opcodes,
// sequencer states, command argument field positions and input-mux encodings.
package core_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned ARG_W     = 8;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned RAM_W     = 16;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned IN_SEL_W  = 2;
  localparam int unsigned CNT_W     = 4;

  // Field positions inside cmd_arg
  localparam int unsigned ARG_ALU_LSB   = 0;
  localparam int unsigned ARG_INSEL_LSB = 4;
  localparam int unsigned ARG_OSEL_BIT  = 6;

  typedef enum logic [OP_W-1:0] {
    OP_SELECT = 3'd0,
    OP_ALU    = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_RESP      = 3'd5
  } seq_state_e;

  // Core input mux encodings driven through input_select
  typedef enum logic [IN_SEL_W-1:0] {
    IN_SEL_BUS  = 2'd0,
    IN_SEL_RAM  = 2'd1,
    IN_SEL_ALU  = 2'd2,
    IN_SEL_SELF = 2'd3
  } in_sel_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ARG_W-1:0]  arg;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_READ);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Host-side command and read-response port of the core sequencer.
interface core_sequencer_if;
  import core_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ARG_W-1:0]  cmd_arg;
  logic [DATA_W-1:0] cmd_data;

  logic              resp_valid;
  logic              resp_ready;
  logic [RAM_W-1:0]  resp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/core_sequencer.sv
// Expands host commands into broadcast-bus and control strobes for the core array
// and returns RAM read-back data on a valid/ready response port.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 2,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  core_sequencer_if.slave     host_if,
  output logic [DATA_W-1:0]   bus_o,
  output logic                save_selection_o,
  output logic                output_enable_o,
  output logic [IN_SEL_W-1:0] input_select_o,
  output logic [ALU_OP_W-1:0] alu_opcode_o,
  output logic                output_select_o,
  input  logic [RAM_W-1:0]    ram_i,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LATENCY - 1);
  localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_LATENCY - 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ARG_W-1:0]    arg_q, arg_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                save_sel_q, save_sel_d;
  logic                oe_q, oe_d;
  logic [IN_SEL_W-1:0] in_sel_q, in_sel_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                out_sel_q, out_sel_d;
  logic                resp_valid_q, resp_valid_d;
  logic [RAM_W-1:0]    resp_data_q, resp_data_d;
  logic                err_q, err_d;
  logic                cmd_accept;

  assign cmd_accept = host_if.cmd_valid && cmd_ready_q;

  // Next state, then every registered output decoded from the state being entered
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    arg_d        = arg_q;
    bus_d        = bus_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          arg_d = host_if.cmd_arg;
          bus_d = host_if.cmd_data;
          if (!op_is_legal(host_if.cmd_op)) begin
            err_d = 1'b1;
          end else begin
            case (cmd_op_e'(host_if.cmd_op))
              OP_SELECT: state_d = ST_SELECT;
              OP_ALU: begin
                state_d = ST_EXEC;
                cnt_d   = ALU_CNT;
              end
              OP_WRITE:  state_d = ST_WRITE;
              OP_READ: begin
                state_d = ST_READ_WAIT;
                cnt_d   = RAM_CNT;
              end
              default:   state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_SELECT, ST_WRITE: state_d = ST_IDLE;
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_READ_WAIT: begin
        if (cnt_q == '0) begin
          resp_data_d = ram_i;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (host_if.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d  = (state_d == ST_IDLE);
    save_sel_d   = (state_d == ST_SELECT);
    oe_d         = (state_d == ST_WRITE) || (state_d == ST_READ_WAIT);
    resp_valid_d = (state_d == ST_RESP);
    alu_op_d     = (state_d == ST_EXEC) ? arg_d[ARG_ALU_LSB +: ALU_OP_W] : '0;
    in_sel_d     = (state_d == ST_EXEC) ? arg_d[ARG_INSEL_LSB +: IN_SEL_W] : in_sel_q;
    out_sel_d    = oe_d ? arg_d[ARG_OSEL_BIT] : out_sel_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      arg_q        <= '0;
      bus_q        <= '0;
      cmd_ready_q  <= 1'b1;
      save_sel_q   <= 1'b0;
      oe_q         <= 1'b0;
      in_sel_q     <= '0;
      alu_op_q     <= '0;
      out_sel_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arg_q        <= arg_d;
      bus_q        <= bus_d;
      cmd_ready_q  <= cmd_ready_d;
      save_sel_q   <= save_sel_d;
      oe_q         <= oe_d;
      in_sel_q     <= in_sel_d;
      alu_op_q     <= alu_op_d;
      out_sel_q    <= out_sel_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign host_if.cmd_ready  = cmd_ready_q;
  assign host_if.resp_valid = resp_valid_q;
  assign host_if.resp_data  = resp_data_q;
  assign bus_o              = bus_q;
  assign save_selection_o   = save_sel_q;
  assign output_enable_o    = oe_q;
  assign input_select_o     = in_sel_q;
  assign alu_opcode_o       = alu_op_q;
  assign output_select_o    = out_sel_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scenario bench for core_sequencer: main instance (ALU 3, RAM 2) plus a second
// instance (ALU 2, RAM 1) fed the same commands for the mid-EXEC reset case.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_arg = '0;
  logic [63:0] cmd_data = '0;
  logic        resp_ready = 1'b0;
  logic [15:0] ram = '0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  core_sequencer_if ifm ();
  core_sequencer_if ifx ();

  assign ifm.cmd_valid  = cmd_valid;
  assign ifm.cmd_op     = cmd_op;
  assign ifm.cmd_arg    = cmd_arg;
  assign ifm.cmd_data   = cmd_data;
  assign ifm.resp_ready = resp_ready;
  assign ifx.cmd_valid  = cmd_valid;
  assign ifx.cmd_op     = cmd_op;
  assign ifx.cmd_arg    = cmd_arg;
  assign ifx.cmd_data   = cmd_data;
  assign ifx.resp_ready = resp_ready;

  logic [63:0] bus_m, bus_x;
  logic        save_m, save_x, oe_m, oe_x, osel_m, osel_x, err_m, err_x;
  logic [1:0]  insel_m, insel_x;
  logic [3:0]  alu_m, alu_x;

  core_sequencer #(.ALU_LATENCY(3), .RAM_LATENCY(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .host_if(ifm), .bus_o(bus_m),
    .save_selection_o(save_m), .output_enable_o(oe_m), .input_select_o(insel_m),
    .alu_opcode_o(alu_m), .output_select_o(osel_m), .ram_i(ram), .err_o(err_m)
  );

  core_sequencer #(.ALU_LATENCY(2), .RAM_LATENCY(1)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .host_if(ifx), .bus_o(bus_x),
    .save_selection_o(save_x), .output_enable_o(oe_x), .input_select_o(insel_x),
    .alu_opcode_o(alu_x), .output_select_o(osel_x), .ram_i(ram), .err_o(err_x)
  );

  // All outputs packed; reset value has only cmd_ready set
  wire [91:0] outs_m = {bus_m, save_m, oe_m, insel_m, alu_m, osel_m,
                        ifm.resp_valid, ifm.resp_data, err_m, ifm.cmd_ready};
  wire [91:0] outs_x = {bus_x, save_x, oe_x, insel_x, alu_x, osel_x,
                        ifx.resp_valid, ifx.resp_data, err_x, ifx.cmd_ready};

  // Presents a command at a negedge, returns at the negedge of the first strobe cycle
  task automatic send(input logic [2:0] op, input logic [7:0] arg, input logic [63:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_data = data;
    while (ifm.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (ifm.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_accept op=%0d: cmd_ready=%b required 1", op, ifm.cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs_m !== 92'd1) begin errors++; $display("FAIL reset_main: outs=%h required %h", outs_m, 92'd1); end
    checks++;
    if (outs_x !== 92'd1) begin errors++; $display("FAIL reset_aux: outs=%h required %h", outs_x, 92'd1); end
    rst_n = 1'b1;
    send(3'(OP_ALU), 8'h05, 64'hCAFE_F00D);
    checks++;
    if (alu_x !== 4'h5 || alu_m !== 4'h5) begin
      errors++; $display("FAIL exec_before_reset: alu aux=%h main=%h required 5", alu_x, alu_m);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outs_x !== 92'd1) begin errors++; $display("FAIL reset_mid_exec_aux: outs=%h required %h", outs_x, 92'd1); end
    checks++;
    if (outs_m !== 92'd1) begin errors++; $display("FAIL reset_mid_exec_main: outs=%h required %h", outs_m, 92'd1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_select;
    send(3'(OP_SELECT), 8'h00, 64'h0000_0000_0012_3456);
    checks++;
    if ({save_m, ifm.cmd_ready} !== 2'b10 || bus_m !== 64'h0000_0000_0012_3456) begin
      errors++; $display("FAIL select_strobe: save=%b ready=%b bus=%h required 1 0 0000000000123456",
                         save_m, ifm.cmd_ready, bus_m);
    end
    @(negedge clk);
    checks++;
    if ({save_m, ifm.cmd_ready} !== 2'b01 || bus_m !== 64'h0000_0000_0012_3456) begin
      errors++; $display("FAIL select_after: save=%b ready=%b bus=%h required 0 1 0000000000123456",
                         save_m, ifm.cmd_ready, bus_m);
    end
  endtask

  task automatic test_alu;
    send(3'(OP_ALU), 8'h27, 64'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alu_m !== 4'h7 || insel_m !== 2'h2 || ifm.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL alu_cycle%0d: alu=%h insel=%h ready=%b required 7 2 0",
                           i, alu_m, insel_m, ifm.cmd_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (alu_m !== 4'h0 || insel_m !== 2'h2 || ifm.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL alu_end: alu=%h insel=%h ready=%b required 0 2 1",
                         alu_m, insel_m, ifm.cmd_ready);
    end
  endtask

  task automatic test_write;
    send(3'(OP_WRITE), 8'h40, 64'h77);
    checks++;
    if (oe_m !== 1'b1 || osel_m !== 1'b1 || bus_m !== 64'h77) begin
      errors++; $display("FAIL write_strobe: oe=%b osel=%b bus=%h required 1 1 77", oe_m, osel_m, bus_m);
    end
    @(negedge clk);
    checks++;
    if (oe_m !== 1'b0 || osel_m !== 1'b1 || ifm.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL write_after: oe=%b osel=%b ready=%b required 0 1 1", oe_m, osel_m, ifm.cmd_ready);
    end
  endtask

  task automatic test_read;
    logic [15:0] exp;
    exp_q.push_back(16'hBEEF);
    ram = 16'h1111;
    resp_ready = 1'b1;
    send(3'(OP_READ), 8'h40, 64'h0);
    checks++;
    if (oe_m !== 1'b1 || osel_m !== 1'b1 || ifm.resp_valid !== 1'b0) begin
      errors++; $display("FAIL read_wait1: oe=%b osel=%b rvalid=%b required 1 1 0", oe_m, osel_m, ifm.resp_valid);
    end
    @(negedge clk);
    ram = 16'hBEEF;
    checks++;
    if (oe_m !== 1'b1 || ifm.resp_valid !== 1'b0) begin
      errors++; $display("FAIL read_wait2: oe=%b rvalid=%b required 1 0", oe_m, ifm.resp_valid);
    end
    @(negedge clk);
    ram = 16'h0000;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (ifm.resp_valid !== 1'b1 || ifm.resp_data !== exp || oe_m !== 1'b0) begin
      errors++; $display("FAIL read_resp: rvalid=%b data=%h oe=%b required 1 %h 0",
                         ifm.resp_valid, ifm.resp_data, oe_m, exp);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (ifm.resp_valid !== 1'b0 || ifm.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL read_done: rvalid=%b ready=%b required 0 1", ifm.resp_valid, ifm.cmd_ready);
    end
  endtask

  task automatic test_resp_hold;
    logic [15:0] exp;
    int n = 0;
    resp_ready = 1'b0;
    ram = 16'hA5C3;
    exp_q.push_back(16'hA5C3);
    send(3'(OP_READ), 8'h00, 64'h0);
    cmd_valid = 1'b1; cmd_op = 3'(OP_SELECT); cmd_arg = 8'h00; cmd_data = 64'h00AB;
    while (ifm.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    ram = 16'hFFFF;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifm.resp_valid !== 1'b1 || ifm.resp_data !== exp || ifm.cmd_ready !== 1'b0 || save_m !== 1'b0) begin
        errors++; $display("FAIL resp_hold%0d: rvalid=%b data=%h ready=%b save=%b required 1 %h 0 0",
                           i, ifm.resp_valid, ifm.resp_data, ifm.cmd_ready, save_m, exp);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (ifm.resp_valid !== 1'b0 || ifm.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL resp_release: rvalid=%b ready=%b required 0 1", ifm.resp_valid, ifm.cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (save_m !== 1'b1 || bus_m !== 64'h00AB) begin
      errors++; $display("FAIL held_cmd_accept: save=%b bus=%h required 1 ab", save_m, bus_m);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    send(3'd6, 8'hFF, 64'h1);
    checks++;
    if ({err_m, save_m, oe_m, alu_m, ifm.cmd_ready} !== 8'b1000_0001) begin
      errors++; $display("FAIL illegal_op: err=%b save=%b oe=%b alu=%h ready=%b required 1 0 0 0 1",
                         err_m, save_m, oe_m, alu_m, ifm.cmd_ready);
    end
    send(3'(OP_SELECT), 8'h00, 64'h42);
    checks++;
    if (save_m !== 1'b1 || bus_m !== 64'h42 || err_m !== 1'b1) begin
      errors++; $display("FAIL select_after_err: save=%b bus=%h err=%b required 1 42 1", save_m, bus_m, err_m);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_select();
    test_alu();
    test_write();
    test_read();
    test_resp_hold();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
